// File: rtl/l1_load_miss_queue_pkg.sv
// Shared widths, entry state encoding and address split helpers for the L1 load miss queue.
// A line address is {tag, set}; the set index occupies the low bits.
package l1_load_miss_queue_pkg;
  localparam int NUM_ENTRIES        = 4;
  localparam int ENTRY_IDX_WIDTH    = $clog2(NUM_ENTRIES);
  localparam int L1_ADDR_WIDTH      = 26;
  localparam int L1_SET_INDEX_WIDTH = 6;
  localparam int L1_TAG_WIDTH       = L1_ADDR_WIDTH - L1_SET_INDEX_WIDTH;
  localparam int L1_NUM_WAYS        = 4;
  localparam int L1_WAY_WIDTH       = $clog2(L1_NUM_WAYS);

  typedef enum logic [1:0] {
    MQ_IDLE          = 2'd0,
    MQ_WAIT_ISSUE    = 2'd1,
    MQ_WAIT_RESPONSE = 2'd2
  } mq_state_t;

  function automatic logic [L1_TAG_WIDTH-1:0] addr_tag(input logic [L1_ADDR_WIDTH-1:0] addr);
    return addr[L1_ADDR_WIDTH-1:L1_SET_INDEX_WIDTH];
  endfunction

  function automatic logic [L1_SET_INDEX_WIDTH-1:0] addr_set(input logic [L1_ADDR_WIDTH-1:0] addr);
    return addr[L1_SET_INDEX_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/l1_load_miss_queue_arbiter.sv
// Round-robin grant over entries awaiting issue; the pointer moves past an entry only once it is acked.
// Latency: combinational grant from registered pointer/lock state.
// Backpressure: an unacked grant is locked so the presented request stays stable until ack.
module miss_queue_arbiter
  import l1_load_miss_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ENTRIES-1:0]     req,
  input  logic                       ack,
  output logic                       grant_valid,
  output logic [ENTRY_IDX_WIDTH-1:0] grant
);
  logic [ENTRY_IDX_WIDTH-1:0] ptr;
  logic [ENTRY_IDX_WIDTH-1:0] lock_idx;
  logic [ENTRY_IDX_WIDTH-1:0] rr_idx;
  logic [ENTRY_IDX_WIDTH-1:0] cand;
  logic                       lock_vld;
  logic                       rr_found;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr;
    cand     = ptr;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand = ptr + ENTRY_IDX_WIDTH'(i);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    grant_valid = lock_vld | rr_found;
    grant       = lock_vld ? lock_idx : rr_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      lock_idx <= '0;
      lock_vld <= 1'b0;
    end else if (grant_valid) begin
      if (ack) begin
        ptr      <= grant + ENTRY_IDX_WIDTH'(1);
        lock_vld <= 1'b0;
      end else begin
        lock_vld <= 1'b1;
        lock_idx <= grant;
      end
    end
  end
endmodule

// File: rtl/l1_load_miss_queue.sv
// Per-strand L1 load miss tracking: allocate on miss, issue one L2 fill per entry, update tags and wake on fill.
// Latency: miss -> l2req one cycle; l2rsp -> update/wake one cycle. L1_MISS_MERGE_EN merges same-line misses.
// Backpressure: l2req_* hold until l2req_ack_i; an entry blocks its strand until its fill returns.
module l1_load_miss_queue
  import l1_load_miss_queue_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_i,
  input  logic [L1_ADDR_WIDTH-1:0]      miss_addr_i,
  input  logic [L1_WAY_WIDTH-1:0]       miss_way_i,
  input  logic [ENTRY_IDX_WIDTH-1:0]    miss_strand_i,
  output logic                          l2req_valid_o,
  input  logic                          l2req_ack_i,
  output logic [L1_ADDR_WIDTH-1:0]      l2req_addr_o,
  output logic [ENTRY_IDX_WIDTH-1:0]    l2req_entry_o,
  input  logic                          l2rsp_valid_i,
  input  logic [ENTRY_IDX_WIDTH-1:0]    l2rsp_entry_i,
  output logic                          update_o,
  output logic [L1_WAY_WIDTH-1:0]       update_way_o,
  output logic [L1_TAG_WIDTH-1:0]       update_tag_o,
  output logic [L1_SET_INDEX_WIDTH-1:0] update_set_o,
  output logic [NUM_ENTRIES-1:0]        wake_strands_o,
  output logic [NUM_ENTRIES-1:0]        pending_o
);
  mq_state_t                  state  [NUM_ENTRIES];
  logic [L1_ADDR_WIDTH-1:0]   addr_q [NUM_ENTRIES];
  logic [L1_WAY_WIDTH-1:0]    way_q  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]     mask_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]     issue_req;
  logic [NUM_ENTRIES-1:0]     strand_onehot;
  logic                       grant_valid;
  logic [ENTRY_IDX_WIDTH-1:0] grant;
  logic                       rsp_hit;
  logic                       alloc_ok;
  logic                       merge_hit;
  logic [ENTRY_IDX_WIDTH-1:0] merge_idx;

  miss_queue_arbiter u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req         (issue_req),
    .ack         (l2req_ack_i),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign rsp_hit       = l2rsp_valid_i && (state[l2rsp_entry_i] == MQ_WAIT_RESPONSE);
  assign alloc_ok      = miss_i && (state[miss_strand_i] == MQ_IDLE);
  assign strand_onehot = NUM_ENTRIES'(1) << miss_strand_i;
  assign l2req_valid_o = grant_valid;
  assign l2req_entry_o = grant;
  assign l2req_addr_o  = addr_q[grant];

  always_comb begin
    issue_req = '0;
    pending_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      issue_req[i] = (state[i] == MQ_WAIT_ISSUE);
      if (state[i] != MQ_IDLE) pending_o = pending_o | mask_q[i];
    end
  end

`ifdef L1_MISS_MERGE_EN
  // An entry being filled this edge is about to go idle, so a matching miss must allocate afresh.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!merge_hit && state[i] != MQ_IDLE && addr_q[i] == miss_addr_i &&
          !(rsp_hit && l2rsp_entry_i == ENTRY_IDX_WIDTH'(i))) begin
        merge_hit = 1'b1;
        merge_idx = ENTRY_IDX_WIDTH'(i);
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state[i]  <= MQ_IDLE;
        addr_q[i] <= '0;
        way_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (grant_valid && l2req_ack_i && grant == ENTRY_IDX_WIDTH'(i)) state[i] <= MQ_WAIT_RESPONSE;
        if (rsp_hit && l2rsp_entry_i == ENTRY_IDX_WIDTH'(i)) state[i] <= MQ_IDLE;
        if (alloc_ok && merge_hit && merge_idx == ENTRY_IDX_WIDTH'(i)) mask_q[i] <= mask_q[i] | strand_onehot;
        if (alloc_ok && !merge_hit && miss_strand_i == ENTRY_IDX_WIDTH'(i)) begin
          state[i]  <= MQ_WAIT_ISSUE;
          addr_q[i] <= miss_addr_i;
          way_q[i]  <= miss_way_i;
          mask_q[i] <= strand_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_o       <= 1'b0;
      update_way_o   <= '0;
      update_tag_o   <= '0;
      update_set_o   <= '0;
      wake_strands_o <= '0;
    end else begin
      update_o       <= rsp_hit;
      update_way_o   <= rsp_hit ? way_q[l2rsp_entry_i] : '0;
      update_tag_o   <= rsp_hit ? addr_tag(addr_q[l2rsp_entry_i]) : '0;
      update_set_o   <= rsp_hit ? addr_set(addr_q[l2rsp_entry_i]) : '0;
      wake_strands_o <= rsp_hit ? mask_q[l2rsp_entry_i] : '0;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(miss_i && state[miss_strand_i] != MQ_IDLE))
        else $error("miss allocated on busy strand %0d", miss_strand_i);
      assert (!(l2rsp_valid_i && state[l2rsp_entry_i] != MQ_WAIT_RESPONSE))
        else $error("l2 response for entry %0d not awaiting a fill", l2rsp_entry_i);
    end
  end
`endif
endmodule

// File: tb/tb_l1_load_miss_queue.sv
`timescale 1ns/1ps
module tb_l1_load_miss_queue;
  import l1_load_miss_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_i;
  logic [25:0] miss_addr_i;
  logic [1:0]  miss_way_i;
  logic [1:0]  miss_strand_i;
  logic        l2req_valid_o;
  logic        l2req_ack_i;
  logic [25:0] l2req_addr_o;
  logic [1:0]  l2req_entry_o;
  logic        l2rsp_valid_i;
  logic [1:0]  l2rsp_entry_i;
  logic        update_o;
  logic [1:0]  update_way_o;
  logic [L1_TAG_WIDTH-1:0]       update_tag_o;
  logic [L1_SET_INDEX_WIDTH-1:0] update_set_o;
  logic [3:0]  wake_strands_o;
  logic [3:0]  pending_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_load_miss_queue dut (
    .clk(clk), .reset(reset), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .miss_way_i(miss_way_i), .miss_strand_i(miss_strand_i),
    .l2req_valid_o(l2req_valid_o), .l2req_ack_i(l2req_ack_i),
    .l2req_addr_o(l2req_addr_o), .l2req_entry_o(l2req_entry_o),
    .l2rsp_valid_i(l2rsp_valid_i), .l2rsp_entry_i(l2rsp_entry_i),
    .update_o(update_o), .update_way_o(update_way_o), .update_tag_o(update_tag_o),
    .update_set_o(update_set_o), .wake_strands_o(wake_strands_o), .pending_o(pending_o)
  );

  // Reference model: per-strand miss records (0 free, 1 needs an L2 request, 2 awaiting fill).
  int          m_state [4];
  logic [25:0] m_addr  [4];
  logic [1:0]  m_way   [4];
  logic [3:0]  m_mask  [4];
  int          m_ptr;
  int          m_held;
  logic        m_upd;
  logic [1:0]  m_upd_way;
  logic [25:0] m_upd_addr;
  logic [3:0]  m_wake;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_state[k] = 0; m_addr[k] = '0; m_way[k] = '0; m_mask[k] = '0;
    end
    m_ptr = 0; m_held = -1;
    m_upd = 1'b0; m_upd_way = '0; m_upd_addr = '0; m_wake = '0;
  endfunction

  // The request shown on the port: a shown-but-unacked one persists, else next needy strand after the last acked.
  function automatic int m_sel();
    if (m_held >= 0) return m_held;
    for (int k = 0; k < 4; k++)
      if (m_state[(m_ptr + k) % 4] == 1) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_pending();
    logic [3:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) if (m_state[k] != 0) p = p | m_mask[k];
    return p;
  endfunction

  function automatic void model_edge(input logic mi, input logic [1:0] ms, input logic [25:0] ma,
                                     input logic [1:0] mw, input logic ak, input logic rv, input logic [1:0] re);
    int   sel;
    logic done;
    logic merged;
    sel    = m_sel();
    done   = rv && (m_state[re] == 2);
    merged = 1'b0;
    m_upd      = done;
    m_upd_way  = done ? m_way[re]  : 2'd0;
    m_upd_addr = done ? m_addr[re] : 26'd0;
    m_wake     = done ? m_mask[re] : 4'd0;
    if (mi && m_state[ms] == 0) begin
`ifdef L1_MISS_MERGE_EN
      for (int j = 0; j < 4; j++)
        if (!merged && m_state[j] != 0 && m_addr[j] == ma && !(done && int'(re) == j)) begin
          m_mask[j] = m_mask[j] | (4'b0001 << ms);
          merged = 1'b1;
        end
`endif
      if (!merged) begin
        m_state[ms] = 1; m_addr[ms] = ma; m_way[ms] = mw; m_mask[ms] = 4'b0001 << ms;
      end
    end
    if (done) m_state[re] = 0;
    if (sel >= 0) begin
      if (ak) begin m_state[sel] = 2; m_ptr = (sel + 1) % 4; m_held = -1; end
      else m_held = sel;
    end
  endfunction

  task automatic cycle(input logic mi, input logic [1:0] ms, input logic [25:0] ma, input logic [1:0] mw,
                       input logic ak, input logic rv, input logic [1:0] re);
    miss_i = mi; miss_strand_i = ms; miss_addr_i = ma; miss_way_i = mw;
    l2req_ack_i = ak; l2rsp_valid_i = rv; l2rsp_entry_i = re;
    model_edge(mi, ms, ma, mw, ak, rv, re);
    @(posedge clk); #1;
    miss_i = 1'b0; l2req_ack_i = 1'b0; l2rsp_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (l2req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", l2req_valid_o); end
    checks++; if (l2req_addr_o !== 26'd0) begin errors++; $display("FAIL reset_req_addr got=%h exp=0", l2req_addr_o); end
    checks++; if (pending_o !== 4'd0) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending_o); end
    checks++; if ({update_o, update_way_o, update_tag_o, update_set_o} !== '0) begin errors++; $display("FAIL reset_update got=%0b/%0d/%h/%h exp=0", update_o, update_way_o, update_tag_o, update_set_o); end
    checks++; if (wake_strands_o !== 4'd0) begin errors++; $display("FAIL reset_wake got=%b exp=0000", wake_strands_o); end
  endtask

  task automatic test_single_miss();
    logic [25:0] a;
    logic [L1_TAG_WIDTH-1:0] et;
    logic [L1_SET_INDEX_WIDTH-1:0] es;
    a = 26'h0123456; et = a[25:L1_SET_INDEX_WIDTH]; es = a[L1_SET_INDEX_WIDTH-1:0];
    do_reset();
    cycle(1'b1, 2'd1, a, 2'd2, 1'b0, 1'b0, 2'd0);
    checks++; if (l2req_valid_o !== 1'b1 || l2req_entry_o !== 2'd1) begin errors++; $display("FAIL single_req got=%0b/%0d exp=1/1", l2req_valid_o, l2req_entry_o); end
    checks++; if (l2req_addr_o !== a) begin errors++; $display("FAIL single_req_addr got=%h exp=%h", l2req_addr_o, a); end
    checks++; if (pending_o !== 4'b0010) begin errors++; $display("FAIL single_pending got=%b exp=0010", pending_o); end
    idle(1);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    checks++; if (l2req_valid_o !== 1'b0) begin errors++; $display("FAIL single_req_after_ack got=%0b exp=0", l2req_valid_o); end
    idle(4);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd1);
    checks++; if (update_o !== 1'b1 || update_way_o !== 2'd2) begin errors++; $display("FAIL single_update got=%0b way %0d exp=1 way 2", update_o, update_way_o); end
    checks++; if (update_tag_o !== et || update_set_o !== es) begin errors++; $display("FAIL single_tagset got=%h/%h exp=%h/%h", update_tag_o, update_set_o, et, es); end
    checks++; if (wake_strands_o !== 4'b0010 || pending_o !== 4'b0000) begin errors++; $display("FAIL single_wake got=%b pend %b exp=0010 pend 0000", wake_strands_o, pending_o); end
    idle(1);
    checks++; if (update_o !== 1'b0 || wake_strands_o !== 4'd0) begin errors++; $display("FAIL single_pulse got=%0b/%b exp=0/0000", update_o, wake_strands_o); end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 26'h100 + 26'(s) * 26'h40, 2'(s), 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        checks++; if (l2req_valid_o !== 1'b1 || l2req_entry_o !== 2'(k)) begin errors++; $display("FAIL rr_hold got=%0b/%0d exp=1/%0d", l2req_valid_o, l2req_entry_o, k); end
        idle(1);
      end
      checks++; if (l2req_addr_o !== 26'h100 + 26'(k) * 26'h40) begin errors++; $display("FAIL rr_addr got=%h entry %0d", l2req_addr_o, k); end
      cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    end
    checks++; if (l2req_valid_o !== 1'b0 || pending_o !== 4'b1111) begin errors++; $display("FAIL rr_all_issued got=%0b pend %b exp=0 pend 1111", l2req_valid_o, pending_o); end
    for (int k = 3; k >= 0; k--) begin
      cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'(k));
      checks++; if (update_o !== 1'b1 || wake_strands_o !== (4'b0001 << k)) begin errors++; $display("FAIL rr_fill got=%0b/%b entry %0d", update_o, wake_strands_o, k); end
    end
  endtask

  task automatic test_merge();
    logic [25:0] a;
    a = 26'h2ABCDE;
    do_reset();
    cycle(1'b1, 2'd0, a, 2'd1, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 2'd2, a, 2'd3, 1'b0, 1'b0, 2'd0);
    checks++; if (pending_o !== 4'b0101) begin errors++; $display("FAIL merge_pending got=%b exp=0101", pending_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
`ifdef L1_MISS_MERGE_EN
    checks++; if (l2req_valid_o !== 1'b0) begin errors++; $display("FAIL merge_single_req got=%0b exp=0", l2req_valid_o); end
`else
    checks++; if (l2req_valid_o !== 1'b1 || l2req_entry_o !== 2'd2) begin errors++; $display("FAIL merge_second_req got=%0b/%0d exp=1/2", l2req_valid_o, l2req_entry_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
`endif
    idle(2);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd0);
`ifdef L1_MISS_MERGE_EN
    checks++; if (update_o !== 1'b1 || wake_strands_o !== 4'b0101) begin errors++; $display("FAIL merge_wake got=%0b/%b exp=1/0101", update_o, wake_strands_o); end
`else
    checks++; if (update_o !== 1'b1 || wake_strands_o !== 4'b0001) begin errors++; $display("FAIL merge_wake0 got=%0b/%b exp=1/0001", update_o, wake_strands_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd2);
    checks++; if (update_o !== 1'b1 || update_way_o !== 2'd3 || wake_strands_o !== 4'b0100) begin errors++; $display("FAIL merge_wake2 got=%0b way %0d %b exp=1 way 3 0100", update_o, update_way_o, wake_strands_o); end
`endif
    checks++; if (pending_o !== 4'b0000) begin errors++; $display("FAIL merge_drained got=%b exp=0000", pending_o); end
  endtask

  task automatic test_rsp_and_alloc();
    do_reset();
    cycle(1'b1, 2'd0, 26'h0000AA, 2'd0, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 2'd3, 26'h3F0F0F, 2'd1, 1'b0, 1'b1, 2'd0);
    checks++; if (update_o !== 1'b1 || wake_strands_o !== 4'b0001) begin errors++; $display("FAIL same_cycle_fill got=%0b/%b exp=1/0001", update_o, wake_strands_o); end
    checks++; if (l2req_valid_o !== 1'b1 || l2req_entry_o !== 2'd3 || l2req_addr_o !== 26'h3F0F0F) begin errors++; $display("FAIL same_cycle_alloc got=%0b/%0d/%h exp=1/3/3f0f0f", l2req_valid_o, l2req_entry_o, l2req_addr_o); end
    checks++; if (pending_o !== 4'b1000) begin errors++; $display("FAIL same_cycle_pending got=%b exp=1000", pending_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 2'd2, 26'h155555, 2'd2, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 2'd1, 26'h0AAAAA, 2'd1, 1'b1, 1'b0, 2'd0);
    reset = 1'b1; model_reset();
    #1;
    checks++; if (l2req_valid_o !== 1'b0 || pending_o !== 4'd0) begin errors++; $display("FAIL mid_reset_immediate got=%0b pend %b exp=0 pend 0000", l2req_valid_o, pending_o); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd2);
    checks++; if (update_o !== 1'b0 || wake_strands_o !== 4'd0) begin errors++; $display("FAIL mid_reset_stale_rsp got=%0b/%b exp=0/0000", update_o, wake_strands_o); end
  endtask

  task automatic test_illegal();
    logic [25:0] a;
    a = 26'h1C3A5B;
    do_reset();
    cycle(1'b1, 2'd1, a, 2'd1, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 2'd1, 26'h000777, 2'd3, 1'b0, 1'b0, 2'd0);
    checks++; if (l2req_addr_o !== a || l2req_entry_o !== 2'd1 || pending_o !== 4'b0010) begin errors++; $display("FAIL illegal_alloc got=%h/%0d/%b exp=%h/1/0010", l2req_addr_o, l2req_entry_o, pending_o, a); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd1);
    checks++; if (update_o !== 1'b0 || l2req_valid_o !== 1'b1) begin errors++; $display("FAIL illegal_rsp_issue got=%0b/%0b exp=0/1", update_o, l2req_valid_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd3);
    checks++; if (update_o !== 1'b0 || wake_strands_o !== 4'd0) begin errors++; $display("FAIL illegal_rsp_idle got=%0b/%b exp=0/0000", update_o, wake_strands_o); end
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 2'd0, 26'd0, 2'd0, 1'b0, 1'b1, 2'd1);
    checks++; if (update_o !== 1'b1 || update_way_o !== 2'd1 || update_set_o !== a[L1_SET_INDEX_WIDTH-1:0]) begin errors++; $display("FAIL illegal_kept_entry got=%0b way %0d set %h", update_o, update_way_o, update_set_o); end
  endtask

  task automatic test_random();
    logic [25:0] pool [4];
    pool[0] = 26'h0012345; pool[1] = 26'h3ABCDEF; pool[2] = 26'h1000040; pool[3] = 26'h2FFFFC0;
    for (int c = 0; c < 800; c++) begin
      int         sel;
      logic [3:0] pend;
      logic [1:0] st, re;
      logic       mi, ak, rv;
      logic [L1_TAG_WIDTH-1:0]       et;
      logic [L1_SET_INDEX_WIDTH-1:0] es;
      sel = m_sel(); pend = m_pending();
      et = m_upd_addr[25:L1_SET_INDEX_WIDTH]; es = m_upd_addr[L1_SET_INDEX_WIDTH-1:0];
      checks++; if (l2req_valid_o !== (sel >= 0)) begin errors++; $display("FAIL rand_req_valid cyc %0d got=%0b exp=%0b", c, l2req_valid_o, sel >= 0); end
      if (sel >= 0) begin
        checks++; if (l2req_entry_o !== 2'(sel) || l2req_addr_o !== m_addr[sel]) begin errors++; $display("FAIL rand_req cyc %0d got=%0d/%h exp=%0d/%h", c, l2req_entry_o, l2req_addr_o, sel, m_addr[sel]); end
      end
      checks++; if (pending_o !== pend) begin errors++; $display("FAIL rand_pending cyc %0d got=%b exp=%b", c, pending_o, pend); end
      checks++; if (update_o !== m_upd || update_way_o !== m_upd_way) begin errors++; $display("FAIL rand_update cyc %0d got=%0b/%0d exp=%0b/%0d", c, update_o, update_way_o, m_upd, m_upd_way); end
      checks++; if (update_tag_o !== et || update_set_o !== es) begin errors++; $display("FAIL rand_tagset cyc %0d got=%h/%h exp=%h/%h", c, update_tag_o, update_set_o, et, es); end
      checks++; if (wake_strands_o !== m_wake) begin errors++; $display("FAIL rand_wake cyc %0d got=%b exp=%b", c, wake_strands_o, m_wake); end
      st = 2'($urandom_range(0, 3));
      re = 2'($urandom_range(0, 3));
      mi = ($urandom_range(0, 2) == 0) && (m_state[st] == 0) && !pend[st];
      ak = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0) && (m_state[re] == 2);
      cycle(mi, st, pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), ak, rv, re);
    end
  endtask

  initial begin
    reset = 1'b1; miss_i = 1'b0; miss_addr_i = '0; miss_way_i = '0; miss_strand_i = '0;
    l2req_ack_i = 1'b0; l2rsp_valid_i = 1'b0; l2rsp_entry_i = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_miss();
    test_rr_order();
    test_merge();
    test_rsp_and_alloc();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
